// File: rtl/ltile_fabric_pkg.sv
// Shared helpers for the parametrised fabric tile: per-slice config width and field offsets.
package ltile_fabric_pkg;

  // Bits per slice: a 2**k-entry LUT mask plus d_sel, out_sel and sr_en.
  function automatic int unsigned cfg_w(input int unsigned k);
    return (32'd1 << k) + 32'd3;
  endfunction

  // LUT_OFS is from the field base; control offsets are from the end of the mask.
  localparam int unsigned LUT_OFS  = 0;
  localparam int unsigned DSEL_OFS = 0;
  localparam int unsigned OSEL_OFS = 1;
  localparam int unsigned SREN_OFS = 2;

endpackage

// File: rtl/ltile_fle_slice.sv
// One fabric slice: K-input LUT, scan-capable FF, D-select and output-select muxes.
module ltile_fle_slice
  import ltile_fabric_pkg::*;
#(
  parameter int unsigned LUT_K = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ccff_en_i,
  input  logic                      test_en_i,
  input  logic                      sr_i,
  input  logic [cfg_w(LUT_K)-1:0]   cfg_i,
  input  logic [LUT_K-1:0]          lut_in_i,
  input  logic                      chain_i,
  input  logic                      scan_i,
  output logic                      q_o,
  output logic                      out_o
);

  localparam int unsigned MASK_W = 2 ** LUT_K;

  logic [MASK_W-1:0] mask;
  logic              d_sel;
  logic              out_sel;
  logic              sr_en;
  logic              lut_c;
  logic              ff_d;
  logic              ff_q;

  assign mask    = cfg_i[LUT_OFS +: MASK_W];
  assign d_sel   = cfg_i[MASK_W + DSEL_OFS];
  assign out_sel = cfg_i[MASK_W + OSEL_OFS];
  assign sr_en   = cfg_i[MASK_W + SREN_OFS];
  assign lut_c   = mask[lut_in_i];

  // Configuration freezes the FF, then scan, then clear, then normal data.
  always_comb begin
    ff_d = ff_q;
    if (ccff_en_i) begin
      ff_d = ff_q;
    end else if (test_en_i) begin
      ff_d = scan_i;
    end else if (sr_i && sr_en) begin
      ff_d = 1'b0;
    end else if (d_sel) begin
      ff_d = chain_i;
    end else begin
      ff_d = lut_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff_q <= 1'b0;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q_o   = ff_q;
  assign out_o = out_sel ? ff_q : lut_c;

endmodule

// File: rtl/ltile_phy_fabric_param.sv
// Parametrised fabric tile: config shift chain with bit counter and done/overrun status,
// NUM_FLE chained slices, and output gating until the bitstream is fully loaded.
module ltile_phy_fabric_param
  import ltile_fabric_pkg::*;
#(
  parameter int unsigned NUM_FLE = 2,
  parameter int unsigned LUT_K   = 4
) (
  input  logic                       fabric_clk,
  input  logic                       Reset,
  input  logic                       Test_en,
  input  logic                       ccff_en,
  input  logic                       ccff_head,
  input  logic [NUM_FLE*LUT_K-1:0]   fabric_in,
  input  logic                       fabric_reg_in,
  input  logic                       fabric_sc_in,
  input  logic                       fabric_sr,
  output logic [NUM_FLE-1:0]         fabric_out,
  output logic                       fabric_reg_out,
  output logic                       fabric_sc_out,
  output logic                       ccff_tail,
  output logic                       cfg_done,
  output logic                       cfg_overrun
);

  localparam int unsigned CFG_W   = cfg_w(LUT_K);
  localparam int unsigned CFG_LEN = NUM_FLE * CFG_W;
  localparam int unsigned CNT_W   = $clog2(CFG_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);

  logic [CFG_LEN-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovr_q, ovr_d;
  logic               full;
  logic [NUM_FLE-1:0] slice_q;
  logic [NUM_FLE-1:0] slice_out;

  assign full = (cnt_q == CNT_FULL);

  // Shift chain and saturating bit counter; a shift at full count flags overrun.
  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    ovr_d = ovr_q;
    if (ccff_en) begin
      cfg_d = {cfg_q[CFG_LEN-2:0], ccff_head};
      if (full) begin
        ovr_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge fabric_clk) begin
    if (Reset) begin
      cfg_q <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  for (genvar i = 0; i < NUM_FLE; i++) begin : g_fle
    logic chain;
    logic scan;
    if (i == 0) begin : g_head
      assign chain = fabric_reg_in;
      assign scan  = fabric_sc_in;
    end else begin : g_link
      assign chain = slice_q[i-1];
      assign scan  = slice_q[i-1];
    end

    ltile_fle_slice #(
      .LUT_K(LUT_K)
    ) u_slice (
      .clk_i     (fabric_clk),
      .rst_i     (Reset),
      .ccff_en_i (ccff_en),
      .test_en_i (Test_en),
      .sr_i      (fabric_sr),
      .cfg_i     (cfg_q[i*CFG_W +: CFG_W]),
      .lut_in_i  (fabric_in[i*LUT_K +: LUT_K]),
      .chain_i   (chain),
      .scan_i    (scan),
      .q_o       (slice_q[i]),
      .out_o     (slice_out[i])
    );
  end

  assign cfg_done       = full && !ccff_en;
  assign cfg_overrun    = ovr_q;
  assign ccff_tail      = cfg_q[CFG_LEN-1];
  assign fabric_out     = slice_out & {NUM_FLE{cfg_done}};
  assign fabric_reg_out = slice_q[NUM_FLE-1];
  assign fabric_sc_out  = slice_q[NUM_FLE-1];

endmodule

// File: tb/tb_ltile_phy_fabric_param.sv
// Bench for ltile_phy_fabric_param (NUM_FLE=2, LUT_K=4): directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model of the tile.
module tb_ltile_phy_fabric_param;

  localparam int NF = 2;
  localparam int K  = 4;
  localparam int CW = 19;
  localparam int CL = 38;

  logic       fabric_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Test_en = 1'b0;
  logic       ccff_en = 1'b0;
  logic       ccff_head = 1'b0;
  logic [7:0] fabric_in = 8'h00;
  logic       fabric_reg_in = 1'b0;
  logic       fabric_sc_in = 1'b0;
  logic       fabric_sr = 1'b0;
  logic [1:0] fabric_out;
  logic       fabric_reg_out;
  logic       fabric_sc_out;
  logic       ccff_tail;
  logic       cfg_done;
  logic       cfg_overrun;

  int npass = 0;
  int ntotal = 0;
  bit chk_en = 1'b0;

  // Model state: mq[n] is cfg bit n, mff[i] is slice i's FF.
  bit mq[$];
  int mcnt;
  bit movr;
  bit mff[NF];

  always #10 fabric_clk = ~fabric_clk;

  ltile_phy_fabric_param #(.NUM_FLE(NF), .LUT_K(K)) dut (
    .fabric_clk     (fabric_clk),
    .Reset          (Reset),
    .Test_en        (Test_en),
    .ccff_en        (ccff_en),
    .ccff_head      (ccff_head),
    .fabric_in      (fabric_in),
    .fabric_reg_in  (fabric_reg_in),
    .fabric_sc_in   (fabric_sc_in),
    .fabric_sr      (fabric_sr),
    .fabric_out     (fabric_out),
    .fabric_reg_out (fabric_reg_out),
    .fabric_sc_out  (fabric_sc_out),
    .ccff_tail      (ccff_tail),
    .cfg_done       (cfg_done),
    .cfg_overrun    (cfg_overrun)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  function automatic bit mlut(input int i);
    int idx;
    idx = i * CW + int'(fabric_in[i*K +: K]);
    return mq[idx];
  endfunction

  // ofs 0 = d_sel, 1 = out_sel, 2 = sr_en
  function automatic bit mfld(input int i, input int ofs);
    return mq[i * CW + 16 + ofs];
  endfunction

  always @(posedge fabric_clk) begin
    bit nf[NF];
    bit up;
    if (Reset) begin
      mq.delete();
      repeat (CL) mq.push_back(1'b0);
      mcnt = 0;
      movr = 1'b0;
      mff  = '{default: 1'b0};
    end else if (ccff_en) begin
      if (mcnt == CL) movr = 1'b1;
      else mcnt++;
      mq.push_front(ccff_head);
      void'(mq.pop_back());
    end else if (mq.size() == CL) begin
      nf = mff;
      for (int i = 0; i < NF; i++) begin
        up = (i == 0) ? (Test_en ? fabric_sc_in : fabric_reg_in) : mff[i-1];
        if (Test_en) nf[i] = up;
        else if (fabric_sr && mfld(i, 2)) nf[i] = 1'b0;
        else if (mfld(i, 0)) nf[i] = up;
        else nf[i] = mlut(i);
      end
      mff = nf;
    end
  end

  always @(negedge fabric_clk) begin
    bit done;
    bit [1:0] eo;
    if (chk_en) begin
      done = (mcnt == CL) && !ccff_en;
      for (int i = 0; i < NF; i++) eo[i] = done && (mfld(i, 1) ? mff[i] : mlut(i));
      check("fabric_out", fabric_out, eo);
      check("fabric_reg_out", fabric_reg_out, mff[NF-1]);
      check("fabric_sc_out", fabric_sc_out, mff[NF-1]);
      check("ccff_tail", ccff_tail, mq[CL-1]);
      check("cfg_done", cfg_done, done);
      check("cfg_overrun", cfg_overrun, movr);
    end
  end

  task automatic tick();
    @(posedge fabric_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic shift_bit(input bit b);
    ccff_en   = 1'b1;
    ccff_head = b;
    tick();
  endtask

  task automatic load(input bit [37:0] v);
    Reset   = 1'b1;
    ccff_en = 1'b0;
    tick();
    Reset = 1'b0;
    for (int n = CL - 1; n >= 0; n--) shift_bit(v[n]);
    ccff_en = 1'b0;
  endtask

  function automatic bit [37:0] mkcfg(input bit [15:0] m0, input bit d0, input bit o0, input bit s0,
                                      input bit [15:0] m1, input bit d1, input bit o1, input bit s1);
    return {s1, o1, d1, m1, s0, o0, d0, m0};
  endfunction

  initial begin
    bit [37:0] v;
    int extra;

    tick();
    Reset  = 1'b0;
    chk_en = 1'b1;
    fabric_in = 8'hFF;
    settle();
    check("reset_outs", {fabric_out, fabric_reg_out, fabric_sc_out, ccff_tail, cfg_done, cfg_overrun}, 0);
    check("gated_before_cfg", fabric_out, 0);

    // LUT path: AND-of-4 mask on slice 0.
    v = mkcfg(16'h8000, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
    load(v);
    settle();
    check("cfg_done_rise", cfg_done, 1);
    fabric_in = 8'h0F;
    settle();
    check("lut_in_F", fabric_out[0], 1);
    fabric_in = 8'h0E;
    settle();
    check("lut_in_E", fabric_out[0], 0);

    // Register chain through both FFs.
    v = mkcfg(16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    load(v);
    fabric_reg_in = 1'b0;
    tick();
    tick();
    fabric_reg_in = 1'b1;
    tick();
    fabric_reg_in = 1'b0;
    settle();
    check("chain_ff0_plus1", fabric_out, 2'b01);
    tick();
    settle();
    check("chain_ff1_plus2", fabric_out, 2'b10);
    check("reg_out_plus2", fabric_reg_out, 1);

    // Scan chain.
    Test_en = 1'b1;
    fabric_sc_in = 1'b0;
    tick();
    tick();
    fabric_sc_in = 1'b1;
    tick();
    fabric_sc_in = 1'b0;
    tick();
    settle();
    check("scan_plus2", fabric_sc_out, 1);
    tick();
    settle();
    check("scan_plus3", fabric_sc_out, 0);
    Test_en = 1'b0;

    // Overrun on a 39th shift; first bit sent (slice 1 sr_en = 1) sits at the tail.
    settle();
    check("tail_first_bit", ccff_tail, 1);
    shift_bit(1'b0);
    ccff_en = 1'b0;
    settle();
    check("overrun_set", cfg_overrun, 1);
    check("count_saturated", cfg_done, 1);
    tick();
    tick();
    settle();
    check("overrun_sticky", cfg_overrun, 1);

    // Per-slice synchronous clear.
    v = mkcfg(16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    load(v);
    fabric_reg_in = 1'b1;
    tick();
    tick();
    settle();
    check("sr_setup", fabric_out, 2'b11);
    fabric_sr = 1'b1;
    tick();
    fabric_sr = 1'b0;
    fabric_reg_in = 1'b0;
    settle();
    check("sr_slice_select", fabric_out, 2'b10);

    // Reset on the 20th shift aborts the load; count restarts from zero.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int n = 0; n < 19; n++) shift_bit(1'b1);
    Reset = 1'b1;
    shift_bit(1'b1);
    Reset   = 1'b0;
    ccff_en = 1'b0;
    settle();
    check("abort_tail", ccff_tail, 0);
    check("abort_done", cfg_done, 0);
    v = mkcfg(16'hA5C3, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1);
    for (int n = CL - 1; n >= 1; n--) shift_bit(v[n]);
    ccff_en = 1'b0;
    settle();
    check("done_not_at_37", cfg_done, 0);
    shift_bit(v[0]);
    ccff_en = 1'b0;
    settle();
    check("done_at_38", cfg_done, 1);
    ccff_en = 1'b1;
    settle();
    check("done_falls_comb", cfg_done, 0);
    ccff_en = 1'b0;
    tick();

    // Random loads followed by random user traffic.
    for (int r = 0; r < 10; r++) begin
      v = 38'({$urandom(), $urandom()});
      load(v);
      extra = int'($urandom_range(0, 2));
      repeat (extra) shift_bit(1'($urandom()));
      ccff_en = 1'b0;
      repeat (40) begin
        fabric_in     = 8'($urandom());
        fabric_reg_in = 1'($urandom());
        fabric_sc_in  = 1'($urandom());
        Test_en       = ($urandom() % 6) == 0;
        fabric_sr     = ($urandom() % 3) == 0;
        ccff_en       = ($urandom() % 20) == 0;
        ccff_head     = 1'($urandom());
        Reset         = ($urandom() % 60) == 0;
        tick();
      end
      Reset     = 1'b0;
      ccff_en   = 1'b0;
      Test_en   = 1'b0;
      fabric_sr = 1'b0;
    end
    tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/ltile_phy_fabric_param.md
# ltile_phy_fabric_param

Parametrised successor to the two-FF fabric tile: `NUM_FLE` slices, each built from:
- one `LUT_K`-input LUT,
- one scan-capable FF,
- a D-select mux and an output-select mux,
- a FF-to-FF register chain, scan chain and per-slice configuration chain.

Single-clock variant: configuration shifting and user logic share `fabric_clk`. Shift is qualified by `ccff_en`. The block adds four things the fixed tile lacks: a bit counter with `cfg_done`/`cfg_overrun` status, output gating until configured, configurable per-slice synchronous clear, and user-FF freeze during configuration.

## Interface
- `NUM_FLE`, default 2: number of slices.
- `LUT_K`, default 4: LUT inputs per slice.
- Derived: `CFG_W = 2**LUT_K + 3` bits per slice; `CFG_LEN = NUM_FLE*CFG_W`.

Ports (clock and reset first):
- `fabric_clk`, in, 1: sole clock, rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `Test_en`, in, 1: scan mode.
- `ccff_en`, in, 1: configuration shift enable.
- `ccff_head`, in, 1: configuration serial input.
- `fabric_in`, in, `NUM_FLE*LUT_K`: LUT inputs; slice i uses `[i*LUT_K +: LUT_K]`, bit 0 LSB.
- `fabric_reg_in`, in, 1: register-chain input to FF0.
- `fabric_sc_in`, in, 1: scan input to FF0.
- `fabric_sr`, in, 1: synchronous clear request for slices with `sr_en`=1.
- `fabric_out`, out, `NUM_FLE`: slice outputs.
- `fabric_reg_out`, out, 1: Q of the last FF.
- `fabric_sc_out`, out, 1: Q of the last FF.
- `ccff_tail`, out, 1: `cfg[CFG_LEN-1]`.
- `cfg_done`, out, 1: exactly `CFG_LEN` bits loaded and not shifting.
- `cfg_overrun`, out, 1: sticky; more than `CFG_LEN` bits shifted.

## Operation

**Configuration chain**
- Shift-register `cfg[0..CFG_LEN-1]`.
- On a cycle with `ccff_en`=1: `cfg[0]<=ccff_head` and `cfg[n]<=cfg[n-1]`.
- The first bit shifted in lands at `CFG_LEN-1`, so the bitstream is sent highest index first.

**Slice i field layout**
- Field base is `b=i*CFG_W`.
- `cfg[b +: 2**LUT_K]` is the LUT mask; output = `mask[j]`, where j is the unsigned slice input value.
- `cfg[b+2**LUT_K]` is `d_sel`: 0 = LUT output, 1 = chain input.
- `cfg[b+2**LUT_K+1]` is `out_sel`: 0 = LUT (combinational), 1 = FF Q.
- `cfg[b+2**LUT_K+2]` is `sr_en`.

**Chain input**
- FF0 takes `fabric_reg_in`.
- FF i (i>0) takes Q of FF i-1.
- Scan input follows the same pattern: `fabric_sc_in`, then Q of FF i-1.

**Bit counter** (width `$clog2(CFG_LEN+1)`)
- Increments per shift cycle and saturates at `CFG_LEN`.
- A shift while the count is already `CFG_LEN` sets `cfg_overrun`. The data keeps shifting and surplus bits exit via `ccff_tail`.
- `cfg_done = (count==CFG_LEN) && !ccff_en`.

**FF next-state priority** (highest first)
1. `Reset`: 0.
2. `ccff_en`: hold.
3. `Test_en`: scan input.
4. `fabric_sr && sr_en`: 0.
5. Otherwise: `d_sel` mux output.

**Outputs**
- `fabric_out[i]` is forced 0 whenever `!cfg_done`; otherwise it is the `out_sel` mux output.
- `fabric_reg_out` and `fabric_sc_out` are not gated.

## Timing
- Reset, synchronous: all FFs, `cfg`, counter and `cfg_overrun` go to 0. After the reset edge every output is 0: `fabric_out`, `fabric_reg_out`, `fabric_sc_out`, `ccff_tail`, `cfg_done`, `cfg_overrun`.
- `Reset` mid-shift aborts the load. A new load must start from an empty count.
- LUT path (`out_sel`=0) is combinational from `fabric_in` to `fabric_out`, zero cycles.
- FF path is 1 cycle from D to Q.
- Register chain: `fabric_reg_in` reaches `fabric_reg_out` after `NUM_FLE` cycles with all `d_sel`=1. Scan behaves the same under `Test_en`.
- `cfg_done` rises on the first cycle with `ccff_en`=0 after the `CFG_LEN`-th shift edge. It falls combinationally when `ccff_en` is reasserted.
- Simultaneous `ccff_en` and `Test_en`: configuration wins and the FFs hold.
- `fabric_sr` with `sr_en`=0 has no effect.

## Structure
- Package `ltile_fabric_pkg` holds:
  - function `cfg_w(k)`;
  - localparam offsets `LUT_OFS`, `DSEL_OFS`, `OSEL_OFS`, `SREN_OFS`.
- Sub-module `ltile_fle_slice`: LUT, FF, both muxes and next-state priority, driven by its `cfg` slice. The top-level module instantiates it `NUM_FLE` times via generate.
- Chain register, counter and gating live in the top level.

## Test plan
All scenarios use `NUM_FLE`=2, `LUT_K`=4, so `CFG_W`=19 and `CFG_LEN`=38.
1. Reset, then 38 shifts with mask 16'h8000, `d_sel`=0, `out_sel`=0, `cfg_done` rises → `fabric_in`=4'hF on slice 0 gives `fabric_out[0]`=1 in the same cycle; 4'hE gives 0. Before `cfg_done`, `fabric_out`=0.
2. Both slices `d_sel`=1, `out_sel`=1, pulse `fabric_reg_in`=1 for one cycle → `fabric_out[0]`=1 at +1 cycle; `fabric_out[1]` and `fabric_reg_out`=1 at +2 cycles.
3. `Test_en`=1, shift `fabric_sc_in` pattern 1,0 → `fabric_sc_out` = 1 then 0, at cycles +2 and +3.
4. A 39th shift → `cfg_overrun`=1 (sticky until `Reset`), counter stays 38, and `ccff_tail` emits the first bit sent.
5. Slice 0 `sr_en`=1, slice 1 `sr_en`=0, both FFs hold 1, assert `fabric_sr` → next cycle FF0=0 and FF1=1.
6. Assert `Reset` at the 20th shift cycle → next cycle `cfg` all 0, count 0, `cfg_done`=0, `ccff_tail`=0.
